scan_chain_driver: RTL
======================

// Module: scan_chain_driver
// PURPOSE
//  Parametrised successor of the external scan-chain drive path. Generates scan_clk, scan_data,
//  scan_select and scan_latch for a chain of NUM_DESIGNS x IO_W input/output flops.
//  Adds selectable modes (refresh / write-only / read-only), a programmable scan clock divider
//  and range-checked design selection. Sits between the user-project pads and the scan chain head.
// PARAMETERS
//  NUM_DESIGNS  4   designs on the chain (>=1)
//  IO_W         8   input bits and output bits per design
//  CLK_DIV      2   clk cycles per scan_clk half-period (>=1)
//  SEL_W        8   width of active_sel
// PORTS
//  clk           in   1      system clock
//  resetb        in   1      async active-low reset
//  start         in   1      1-cycle request; sampled only when busy=0
//  mode          in   2      00 refresh (capture+shift+latch), 01 write-only (shift+latch), 10 read-only (capture+shift), 11 = 00
//  active_sel    in   SEL_W  target design index
//  data_in       in   IO_W   value shifted into the target's input flops
//  data_out      out  IO_W   captured outputs of the target; updated with done
//  busy          out  1      operation in progress
//  done          out  1      1-cycle completion pulse
//  sel_err       out  1      high with done when active_sel >= NUM_DESIGNS; held until next start
//  scan_clk      out  1      chain clock
//  scan_data_out out  1      chain head data
//  scan_select   out  1      1 = chain flops capture design outputs
//  scan_latch    out  1      latch-enable pulse to design inputs
//  scan_data_in  in   1      chain tail data
// BEHAVIOUR
//  Reset: all outputs 0, data_out=0, FSM=IDLE. Reset mid-operation aborts immediately; no latch pulse is issued.
//  CHAIN_LEN = NUM_DESIGNS*IO_W. Scan period P = 2*CLK_DIV clk cycles.
//   scan_clk is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles of each P.
//  FSM: IDLE -> (CAPTURE) -> SHIFT -> (LATCH) -> DONE -> IDLE.
//   CAPTURE and LATCH are skipped per mode.
//  Start accepted in cycle 0: busy=1 from cycle 1; inputs registered at acceptance.
//   data_in changes while busy have no effect.
//  Bad sel: start with active_sel >= NUM_DESIGNS -> no scan activity; done=1 and sel_err=1 in cycle 1;
//   busy stays 0; data_out is unchanged.
//  CAPTURE: one P with scan_select=1 and one scan_clk pulse. scan_select drops when the period ends.
//  SHIFT: CHAIN_LEN periods with scan_select=0.
//   Shift bit k (k=0..CHAIN_LEN-1) is driven on scan_data_out for the whole of period k.
//   Bit k targets chain position p = CHAIN_LEN-1-k, i.e. design p/IO_W, bit p%IO_W.
//   It carries data_in[p%IO_W] when p/IO_W = sel, and 0 otherwise.
//  Read: scan_data_in is sampled on the last low-phase cycle of period k. That sample is the captured
//   output at position CHAIN_LEN-1-k; it is stored to data_out[p%IO_W] when p/IO_W = sel.
//  Write-only mode: no capture, data_out unchanged.
//  LATCH: one P with scan_clk=0 and scan_latch=1. Not issued in read-only mode.
//  DONE: done=1 for 1 cycle, busy=0 in the same cycle, data_out valid. A start in that same cycle
//   is ignored; the next start is accepted from the following cycle.
//  Latency from start to done, refresh mode: (CHAIN_LEN+2)*P+1 cycles.
//   Write-only and read-only: (CHAIN_LEN+1)*P+1 cycles.
//  Counters: bit counter width clog2(CHAIN_LEN+1); divider width clog2(CLK_DIV+1); both saturate-free
//   and reload on each phase.
// TESTING (bench models the chain as CHAIN_LEN shift/capture flops; NUM_DESIGNS=4, IO_W=8, CLK_DIV=2)
//  1 Refresh, sel=2, data_in=8'hA5, design2 outputs=8'h3C -> done at cycle 137; data_out=8'h3C;
//    design2 inputs=8'hA5 after latch; designs 0,1,3 inputs=0.
//  2 Write-only, sel=0, data_in=8'hFF -> 0 scan_select pulses, 1 latch pulse; done at cycle 133;
//    data_out unchanged.
//  3 Read-only, sel=3, outputs=8'h81 -> 0 latch pulses; data_out=8'h81; inputs of all designs unchanged.
//  4 start with sel=4 -> done=1, sel_err=1 at cycle 1; busy stays 0; no scan_clk edges.
//    Next valid start clears sel_err.
//  5 resetb low during SHIFT bit 10 -> all outputs 0 asynchronously; no latch pulse;
//    new start after release completes normally.
//  6 start pulsed while busy and in the done cycle -> ignored.
//    Exactly CHAIN_LEN+1 scan_clk rising edges per refresh (1 capture + 32 shift edges).

Source files
------------

// File: rtl/scan_chain_driver.sv
// ---------------------------------------------------------------------------
// scan_chain_driver
//
// Drives an external scan chain of NUM_DESIGNS x IO_W flops. One operation:
// optionally captures every design's outputs into the chain, shifts a full
// chain image through it (target design gets data_in, all others get 0),
// reads the target's captured outputs back from the chain tail, and
// optionally pulses the latch so the designs load their new inputs.
//
// Ports
//   clk, resetb         system clock, asynchronous active-low reset
//   start               one-cycle request, only looked at while idle
//   mode                00/11 refresh, 01 write-only, 10 read-only
//   active_sel          target design index
//   data_in             value for the target's input flops
//   data_out            target's captured outputs, updated with done
//   busy, done          operation in progress / one-cycle completion pulse
//   sel_err             target index out of range; held until next start
//   scan_clk            chain clock
//   scan_data_out       chain head data
//   scan_select         chain capture enable
//   scan_latch          latch-enable pulse to the design inputs
//   scan_data_in        chain tail data
// ---------------------------------------------------------------------------
module scan_chain_driver #(
    parameter int NUM_DESIGNS = 4,
    parameter int IO_W        = 8,
    parameter int CLK_DIV     = 2,
    parameter int SEL_W       = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] active_sel,
    input  logic [IO_W-1:0]  data_in,
    output logic [IO_W-1:0]  data_out,
    output logic             busy,
    output logic             done,
    output logic             sel_err,
    output logic             scan_clk,
    output logic             scan_data_out,
    output logic             scan_select,
    output logic             scan_latch,
    input  logic             scan_data_in
);

    localparam int CHAIN_LEN = NUM_DESIGNS * IO_W;
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int DIV_W     = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, LATCH, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             mode_r;
    logic [SEL_W-1:0]       sel_r;
    logic [CHAIN_LEN-1:0]   chain_sr;
    logic [CHAIN_LEN-1:0]   load_img;
    logic [CHAIN_LEN-1:0]   sr_shifted;
    logic [CHAIN_LEN-1:0]   read_src;
    logic [IO_W-1:0]        sel_slice;
    logic                   sample_bit;
    logic [DIV_W-1:0]       div_cnt;
    logic                   phase;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   accept;
    logic                   sel_bad;
    logic                   half_end;
    logic                   period_end;
    logic                   sample_pt;
    logic                   last_bit;
    logic                   write_only;
    logic                   read_only;
    logic                   active;

    // Decode of the request, the mode and the scan-period timing. A period is
    // a low phase followed by a high phase, each CLK_DIV cycles long; the
    // tail is sampled at the end of the low phase, the chain shifts on the
    // rising edge that follows.
    always_comb begin
        accept     = (state == IDLE) && start;
        sel_bad    = 32'(active_sel) >= 32'(NUM_DESIGNS);
        half_end   = div_cnt == DIV_W'(CLK_DIV - 1);
        period_end = half_end && phase;
        sample_pt  = half_end && !phase;
        last_bit   = bit_cnt == BIT_W'(CHAIN_LEN - 1);
        write_only = mode_r == 2'b01;
        read_only  = mode_r == 2'b10;
        active     = (state == CAPTURE) || (state == SHIFT) || (state == LATCH);
    end

    // Chain image and read-back path. The image places data_in at the
    // target's slot and zero elsewhere; its MSB is shifted out first so that
    // after CHAIN_LEN shifts every bit sits at its own chain position. The
    // same register collects tail samples at its LSB, so once the shift is
    // over it holds the captured outputs in chain order. On the final shift
    // edge the not-yet-registered shifted value is the one to read from.
    always_comb begin
        load_img   = '0;
        sel_slice  = '0;
        sr_shifted = (chain_sr << 1) | CHAIN_LEN'(sample_bit);
        read_src   = (state == SHIFT) ? sr_shifted : chain_sr;
        for (int d = 0; d < NUM_DESIGNS; d++) begin
            if (active_sel == SEL_W'(d)) begin
                load_img[d*IO_W +: IO_W] = data_in;
            end
            if (sel_r == SEL_W'(d)) begin
                sel_slice = read_src[d*IO_W +: IO_W];
            end
        end
    end

    // State register. Pulling resetb low drops straight back to IDLE, which
    // aborts any operation without a latch pulse.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An out-of-range target skips all scan activity and
    // goes straight to DONE. Capture is skipped for write-only, latch for
    // read-only. DONE always returns to IDLE, so a start seen in the done
    // cycle is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (sel_bad) begin
                        state_next = DONE;
                    end else if (mode == 2'b01) begin
                        state_next = SHIFT;
                    end else begin
                        state_next = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (period_end) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (period_end && last_bit) begin
                    state_next = read_only ? DONE : LATCH;
                end
            end
            LATCH: begin
                if (period_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode straight from the state, so an asynchronous reset clears
    // every chain-side output at once.
    always_comb begin
        busy          = active;
        done          = state == DONE;
        scan_clk      = ((state == CAPTURE) || (state == SHIFT)) && phase;
        scan_select   = state == CAPTURE;
        scan_latch    = state == LATCH;
        scan_data_out = (state == SHIFT) && chain_sr[CHAIN_LEN-1];
    end

    // Datapath: request registers, period counters, the chain image shift
    // register and the read-back result. Inputs are captured once at
    // acceptance, so later changes on data_in, mode or active_sel are
    // ignored. data_out only changes on the edge into DONE, and never for
    // write-only or rejected requests.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mode_r     <= '0;
            sel_r      <= '0;
            chain_sr   <= '0;
            sample_bit <= 1'b0;
            div_cnt    <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            data_out   <= '0;
            sel_err    <= 1'b0;
        end else if (accept) begin
            if (sel_bad) begin
                sel_err <= 1'b1;
            end else begin
                sel_err  <= 1'b0;
                mode_r   <= mode;
                sel_r    <= active_sel;
                chain_sr <= load_img;
                div_cnt  <= '0;
                phase    <= 1'b0;
                bit_cnt  <= '0;
            end
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if ((state == SHIFT) && sample_pt) begin
                sample_bit <= scan_data_in;
            end
            if ((state == SHIFT) && period_end) begin
                chain_sr <= sr_shifted;
                bit_cnt  <= bit_cnt + 1'b1;
            end
            if ((state_next == DONE) && !write_only) begin
                data_out <= sel_slice;
            end
        end
    end

endmodule
